// File: rtl/test_rand_delay.sv
// Single-entry test stage: holds each val/rdy message for an LFSR-drawn delay (0..p_max_delay), then presents it unchanged.
// Latency 1+d cycles from accept to out_val; in_rdy only when empty or when the held message leaves this cycle (out_rdy -> in_rdy).
module test_rand_delay #(
  parameter int              p_msg_nbits = 1,
  parameter int              p_max_delay = 0,
  parameter logic [15:0]     p_seed      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg
);

  localparam int          CW   = $clog2(p_max_delay + 2);
  localparam logic [15:0] SEED = (p_seed == 16'h0000) ? 16'h0001 : p_seed;
  localparam logic [15:0] MOD  = 16'(p_max_delay + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  logic [1:0]             r_state;
  logic [p_msg_nbits-1:0] r_hold_msg;
  logic [CW-1:0]          r_cnt;
  logic [15:0]            r_lfsr;

  logic                   w_go_in;
  logic [CW-1:0]          w_delay;
  logic [15:0]            w_lfsr_next;

  assign in_rdy  = !reset && ((r_state == IDLE) || ((r_state == SEND) && out_rdy));
  assign w_go_in = in_val && in_rdy;
  assign out_val = !reset && (r_state == SEND);
  assign out_msg = (!reset && (r_state != IDLE)) ? r_hold_msg : '0;

  // Delay is drawn from the LFSR value before it advances for this accept.
  assign w_delay     = CW'(r_lfsr % MOD);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_lfsr     <= SEED;
      r_cnt      <= '0;
      r_hold_msg <= '0;
    end else if (w_go_in) begin
      r_hold_msg <= in_msg;
      r_lfsr     <= w_lfsr_next;
      if (w_delay == '0) begin
        r_state <= SEND;
      end else begin
        r_cnt   <= w_delay;
        r_state <= DELAY;
      end
    end else begin
      case (r_state)
        DELAY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= SEND;
        end
        SEND: begin
          if (out_rdy) r_state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!$isunknown(in_val) && !$isunknown(out_rdy));
  end

endmodule
